uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised UART receiver, successor to the fixed 8N1 receiver. Configurable data width,
//  bit order, parity, stop bits and oversampling. 3-sample majority vote, 2-flop rx synchroniser.
//  Valid/ready output holding register with overrun, parity, frame and break flags.
//  Sits between the pad-side rx line and the host register/FIFO interface.
// PARAMETERS
//  UART_INPUT_CLK  100_000_000  input clock frequency, Hz
//  baud_rate       9600         line rate, bit/s
//  OVERSAMPLE      16           baud ticks per bit; even, >=8
//  DATA_BITS       8            data bits per frame, 5..9
//  PARITY          0            0 none, 1 odd, 2 even
//  STOP_BITS       1            1 or 2
//  LSB_FIRST       0            0 = MSB first (existing UART convention), 1 = LSB first
//  DIVISOR = UART_INPUT_CLK/(baud_rate*OVERSAMPLE), derived localparam (651 at defaults)
// PORTS
//  clk        in   1          clock, rising edge
//  arst_n     in   1          asynchronous active-low reset
//  rx_en      in   1          receive enable; 0 = stay in / return to IDLE
//  rx         in   1          serial input, idle high, asynchronous to clk
//  busy       out  1          frame in progress (state != IDLE)
//  data       out  DATA_BITS  received word, bit 0 = first-written data LSB of the word
//  data_valid out  1          data/flags hold a completed frame
//  data_ready in   1          consumer accepts when data_valid & data_ready
//  parity_err out  1          parity mismatch on held frame (0 when PARITY=0)
//  frame_err  out  1          any stop bit sampled 0 on held frame
//  break_det  out  1          held frame: all data, parity and stop bits 0
//  overrun    out  1          sticky: frame completed while data_valid=1; cleared on next accept
// BEHAVIOUR
//  Reset (arst_n=0, async): state IDLE, all outputs 0, data=0, tick counter 0, sync flops = 1.
//  rx passes 2 flops (rx_s); all decisions use rx_s. Baud tick: 1-clk pulse every DIVISOR clks,
//   counter reloaded on IDLE->START so the first tick is phase-aligned to the detected edge.
//  Sampling: within each bit, ticks counted 0..OVERSAMPLE-1; samples taken at ticks
//   OVERSAMPLE/2-1, /2, /2+1; bit value = majority of 3.
//  FSM: IDLE  -> START on rx_en & rx_s falling (1->0).
//       START -> majority 1: false start, back to IDLE, nothing reported; else DATA at bit end.
//       DATA  -> DATA_BITS bits shifted per LSB_FIRST; -> PARITY if PARITY!=0 else STOP.
//       PARITY-> one bit, compared against XOR(data) (even) or ~XOR (odd); -> STOP.
//       STOP  -> STOP_BITS bits; at majority decision of last stop bit, frame completes, -> IDLE
//                immediately (no wait for bit end, so back-to-back frames with 1 stop bit work).
//  Completion (1 clk after last stop majority): data/flags loaded, data_valid<=1.
//   If data_valid already 1 and not accepted that cycle: old data/flags kept, overrun<=1.
//   Accept and completion in same cycle: new frame loaded, data_valid stays 1, no overrun.
//  Accept: data_valid<=0 next clk; overrun cleared on the accept edge.
//  rx_en=0 mid-frame: abort to IDLE next clk, partial frame discarded, held output untouched.
//  Break: frame_err and break_det both set; after break, FSM waits in IDLE for rx_s=1 before
//   rearming edge detect (no repeated frames while line held low).
//  busy=1 from START entry through STOP exit, combinational from state register.
// STRUCTURE
//  Shared package uart_pkg: state encoding (IDLE/START/DATA/PARITY/STOP), PARITY_NONE/ODD/EVEN
//   constants, divisor computation function; to be reused by the matching transmitter.
//  Sub-module uart_baud_gen (DIVISOR, sync reload input, tick output); everything else in top.
// TESTING  (defaults unless stated; bit period = 651*16*10 ns = 104160 ns)
//  8N1 MSB-first 0xD6 then 0xD4 back-to-back, data_ready=1 -> two accepts, data=0xD6,0xD4, no flags.
//  DATA_BITS=7, PARITY=2, LSB_FIRST=1, send 0x41 with wrong parity bit -> data=0x41, parity_err=1.
//  Stop bit driven 0, data 0x55 -> data=0x55, frame_err=1, break_det=0; all-zero frame -> break_det=1,
//   no second frame until rx returns high.
//  Glitch: rx low for 3*651 clks only -> busy pulses, returns IDLE, data_valid stays 0.
//  data_ready=0, send 0x11 then 0x22 -> data=0x11, overrun=1; assert ready -> overrun=0, data_valid=0.
//  arst_n pulsed low mid-DATA of 0xA5 -> all outputs 0 immediately; next frame 0x3C received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, parity modes and the
// baud divisor helper used by both receiver and transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic int calc_divisor(
    input int clk_hz,
    input int baud,
    input int os
  );
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-clock pulse every DIVISOR clocks,
// restartable so the first tick lines up with a detected start edge.
module uart_baud_gen #(
  parameter int DIVISOR = 651
) (
  input  logic clk,
  input  logic arst_n,
  input  logic reload_i,
  output logic tick_o
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(DIVISOR - 1));

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    if (reload_i) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: majority-voted oversampling, optional
// parity, 1/2 stop bits, valid/ready holding register with error flags.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int UART_INPUT_CLK = 100_000_000,
  parameter int baud_rate      = 9600,
  parameter int OVERSAMPLE     = 16,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int LSB_FIRST      = 0
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 rx_en,
  input  logic                 rx,
  output logic                 busy,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);

  localparam int DIVISOR =
    calc_divisor(UART_INPUT_CLK, baud_rate, OVERSAMPLE);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int S0 = OVERSAMPLE / 2 - 1;
  localparam int S1 = OVERSAMPLE / 2;
  localparam int S2 = OVERSAMPLE / 2 + 1;

  logic rx_m_q, rx_s_q, rx_p_q;
  logic fall, tick, reload;

  uart_state_e state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [1:0] scnt_q, scnt_d;
  logic [1:0] smp_q, smp_d;
  logic [DATA_BITS-1:0] shf_q, shf_d;
  logic perr_q, perr_d;
  logic ferr_q, ferr_d;
  logic zero_q, zero_d;

  logic smp0, smp1, smp2, bit_end, maj, exp_par, done;

  logic dv_q, dv_d, ov_q, ov_d;
  logic pe_q, pe_d, fe_q, fe_d, bk_q, bk_d;
  logic [DATA_BITS-1:0] dat_q, dat_d;
  logic accept;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_p_q <= 1'b1;
    end else begin
      rx_m_q <= rx;
      rx_s_q <= rx_m_q;
      rx_p_q <= rx_s_q;
    end
  end

  // A line held low after a break never re-fires: a new edge needs rx_s high first
  assign fall = rx_p_q & ~rx_s_q;

  assign reload = (state_q == ST_IDLE) && (state_d == ST_START);

  uart_baud_gen #(
    .DIVISOR(DIVISOR)
  ) u_baud (
    .clk     (clk),
    .arst_n  (arst_n),
    .reload_i(reload),
    .tick_o  (tick)
  );

  assign smp0    = tick && (tcnt_q == TW'(S0));
  assign smp1    = tick && (tcnt_q == TW'(S1));
  assign smp2    = tick && (tcnt_q == TW'(S2));
  assign bit_end = tick && (tcnt_q == TW'(OVERSAMPLE - 1));
  assign maj     = (smp_q[0] & smp_q[1]) |
                   ((smp_q[0] | smp_q[1]) & rx_s_q);
  assign exp_par = (PARITY == PARITY_EVEN) ? ^shf_q : ~^shf_q;
  assign busy    = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    scnt_d  = scnt_q;
    smp_d   = smp_q;
    shf_d   = shf_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    zero_d  = zero_q;
    done    = 1'b0;
    if (tick) begin
      tcnt_d = bit_end ? '0 : tcnt_q + TW'(1);
    end
    if (smp0) smp_d[0] = rx_s_q;
    if (smp1) smp_d[1] = rx_s_q;
    unique case (state_q)
      ST_IDLE: begin
        tcnt_d = '0;
        bcnt_d = '0;
        scnt_d = '0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        zero_d = 1'b1;
        if (rx_en && fall) state_d = ST_START;
      end
      ST_START: begin
        if (smp2 && maj) state_d = ST_IDLE;
        else if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (smp2) begin
          if (LSB_FIRST != 0) shf_d = {maj, shf_q[DATA_BITS-1:1]};
          else                shf_d = {shf_q[DATA_BITS-2:0], maj};
          bcnt_d = bcnt_q + BW'(1);
          zero_d = zero_q & ~maj;
        end
        if (bit_end && (bcnt_q == BW'(DATA_BITS))) begin
          state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (smp2) begin
          perr_d = (maj != exp_par);
          zero_d = zero_q & ~maj;
        end
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (smp2) begin
          ferr_d = ferr_q | ~maj;
          zero_d = zero_q & ~maj;
          if (scnt_q == 2'(STOP_BITS - 1)) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            scnt_d = scnt_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!rx_en) begin
      state_d = ST_IDLE;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      scnt_q  <= '0;
      smp_q   <= '0;
      shf_q   <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      scnt_q  <= scnt_d;
      smp_q   <= smp_d;
      shf_q   <= shf_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      zero_q  <= zero_d;
    end
  end

  assign accept = dv_q & data_ready;

  always_comb begin
    dv_d  = dv_q;
    ov_d  = ov_q;
    dat_d = dat_q;
    pe_d  = pe_q;
    fe_d  = fe_q;
    bk_d  = bk_q;
    if (accept) begin
      dv_d = 1'b0;
      ov_d = 1'b0;
    end
    // A new frame only displaces held data that is leaving this cycle
    if (done) begin
      if (!dv_q || accept) begin
        dv_d  = 1'b1;
        dat_d = shf_q;
        pe_d  = perr_q;
        fe_d  = ferr_q | ~maj;
        bk_d  = zero_q & ~maj;
      end else begin
        ov_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      dv_q  <= 1'b0;
      ov_q  <= 1'b0;
      dat_q <= '0;
      pe_q  <= 1'b0;
      fe_q  <= 1'b0;
      bk_q  <= 1'b0;
    end else begin
      dv_q  <= dv_d;
      ov_q  <= ov_d;
      dat_q <= dat_d;
      pe_q  <= pe_d;
      fe_q  <= fe_d;
      bk_q  <= bk_d;
    end
  end

  assign data       = dat_q;
  assign data_valid = dv_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign break_det  = bk_q;
  assign overrun    = ov_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench: 8N1 MSB-first instance plus a 7E1 LSB-first
// instance, both at 4 clocks per oversample tick.
module tb_uart_rx_cfg;

  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD   = 1_562_500;
  localparam int OS     = 16;
  localparam int DIV    = 4;
  localparam int BIT    = DIV * OS;

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       bk;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arst_n, rx_en, rx_a, rx_b, rdy_a, rdy_b;
  logic busy_a, dv_a, pe_a, fe_a, bk_a, ov_a;
  logic busy_b, dv_b, pe_b, fe_b, bk_b, ov_b;
  logic [7:0] data_a;
  logic [6:0] data_b;

  rec_t exp_a[$], obs_a[$], exp_b[$], obs_b[$];
  rec_t e, o;
  int n_cmp = 0;
  int n_bad = 0;
  logic busy_seen_a;

  uart_rx_cfg #(
    .UART_INPUT_CLK(CLK_HZ), .baud_rate(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .LSB_FIRST(0)
  ) dut_a (
    .clk(clk), .arst_n(arst_n), .rx_en(rx_en), .rx(rx_a),
    .busy(busy_a), .data(data_a), .data_valid(dv_a),
    .data_ready(rdy_a), .parity_err(pe_a), .frame_err(fe_a),
    .break_det(bk_a), .overrun(ov_a)
  );

  uart_rx_cfg #(
    .UART_INPUT_CLK(CLK_HZ), .baud_rate(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .LSB_FIRST(1)
  ) dut_b (
    .clk(clk), .arst_n(arst_n), .rx_en(rx_en), .rx(rx_b),
    .busy(busy_b), .data(data_b), .data_valid(dv_b),
    .data_ready(rdy_b), .parity_err(pe_b), .frame_err(fe_b),
    .break_det(bk_b), .overrun(ov_b)
  );

  always @(negedge clk) begin
    #1;
    if (dv_a && rdy_a) obs_a.push_back({1'b0, data_a, pe_a, fe_a, bk_a});
    if (dv_b && rdy_b) obs_b.push_back({2'b0, data_b, pe_b, fe_b, bk_b});
    if (busy_a) busy_seen_a = 1'b1;
  end

  function automatic rec_t mk(input logic [8:0] d, input logic pe,
                              input logic fe, input logic bk);
    return {d, pe, fe, bk};
  endfunction

  function automatic logic [15:0] fr_a(input logic [7:0] d, input logic stp);
    logic [15:0] s;
    s = '1;
    s[0] = 1'b0;
    for (int i = 0; i < 8; i++) s[1+i] = d[7-i];
    s[9] = stp;
    return s;
  endfunction

  function automatic logic [15:0] fr_b(input logic [6:0] d, input logic par,
                                       input logic stp);
    logic [15:0] s;
    s = '1;
    s[0] = 1'b0;
    for (int i = 0; i < 7; i++) s[1+i] = d[i];
    s[8] = par;
    s[9] = stp;
    return s;
  endfunction

  task automatic send_a(input logic [15:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      rx_a = s[i];
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic send_b(input logic [15:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      rx_b = s[i];
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic wait_obs_a(input int n);
    int t = 0;
    while (obs_a.size() < n && t < 4 * BIT) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic wait_obs_b(input int n);
    int t = 0;
    while (obs_b.size() < n && t < 4 * BIT) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1; rx_en = 1'b1;
    rdy_a = 1'b1; rdy_b = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({busy_a, dv_a, pe_a, fe_a, bk_a, ov_a, data_a} !== 14'h0) begin
      n_bad++;
      $display("FAIL reset_a got %h want 0",
               {busy_a, dv_a, pe_a, fe_a, bk_a, ov_a, data_a});
    end
    n_cmp++;
    if ({busy_b, dv_b, pe_b, fe_b, bk_b, ov_b, data_b} !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_b got %h want 0",
               {busy_b, dv_b, pe_b, fe_b, bk_b, ov_b, data_b});
    end
    @(negedge clk);
    arst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    n_cmp++;
    if ({busy_a, dv_a, ov_a, data_a} !== 11'h0) begin
      n_bad++;
      $display("FAIL post_reset_a got %h want 0", {busy_a, dv_a, ov_a, data_a});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    rdy_a = 1'b1;
    exp_a.push_back(mk(9'h0D6, 0, 0, 0));
    exp_a.push_back(mk(9'h0D4, 0, 0, 0));
    send_a(fr_a(8'hD6, 1'b1), 10);
    send_a(fr_a(8'hD4, 1'b1), 10);
    send_a('1, 2);
    wait_obs_a(2);
    n_cmp++;
    if (obs_a.size() !== exp_a.size()) begin
      n_bad++;
      $display("FAIL b2b_count got %0d want %0d", obs_a.size(), exp_a.size());
    end
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front();
      n_cmp++;
      if (obs_a.size() == 0) begin
        n_bad++;
        $display("FAIL b2b_word got none want %h", e);
      end else begin
        o = obs_a.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL b2b_word got %h want %h", o, e);
        end
      end
    end
    obs_a.delete();
  endtask

  task automatic test_parity();
    rdy_b = 1'b1;
    exp_b.push_back(mk(9'h041, 1, 0, 0));
    send_b(fr_b(7'h41, 1'b1, 1'b1), 10);
    send_b('1, 2);
    exp_b.push_back(mk(9'h007, 0, 0, 0));
    send_b(fr_b(7'h07, 1'b1, 1'b1), 10);
    send_b('1, 2);
    wait_obs_b(2);
    n_cmp++;
    if (obs_b.size() !== exp_b.size()) begin
      n_bad++;
      $display("FAIL par_count got %0d want %0d", obs_b.size(), exp_b.size());
    end
    while (exp_b.size() != 0) begin
      e = exp_b.pop_front();
      n_cmp++;
      if (obs_b.size() == 0) begin
        n_bad++;
        $display("FAIL par_word got none want %h", e);
      end else begin
        o = obs_b.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL par_word got %h want %h", o, e);
        end
      end
    end
    obs_b.delete();
  endtask

  task automatic test_frame_break();
    rdy_a = 1'b1;
    exp_a.push_back(mk(9'h055, 0, 1, 0));
    send_a(fr_a(8'h55, 1'b0), 10);
    send_a('1, 2);
    exp_a.push_back(mk(9'h000, 0, 1, 1));
    send_a(fr_a(8'h00, 1'b0), 10);
    send_a('0, 3);
    #1;
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_bad++;
      $display("FAIL brk_busy got %b want 0", busy_a);
    end
    n_cmp++;
    if (obs_a.size() !== 2) begin
      n_bad++;
      $display("FAIL brk_count got %0d want 2", obs_a.size());
    end
    send_a('1, 2);
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front();
      n_cmp++;
      if (obs_a.size() == 0) begin
        n_bad++;
        $display("FAIL ferr_word got none want %h", e);
      end else begin
        o = obs_a.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL ferr_word got %h want %h", o, e);
        end
      end
    end
    obs_a.delete();
  endtask

  task automatic test_glitch();
    busy_seen_a = 1'b0;
    rx_a = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    rx_a = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    #1;
    n_cmp++;
    if (busy_seen_a !== 1'b1) begin
      n_bad++;
      $display("FAIL glitch_busy_seen got %b want 1", busy_seen_a);
    end
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_busy got %b want 0", busy_a);
    end
    n_cmp++;
    if ({dv_a, 8'(obs_a.size())} !== 9'h0) begin
      n_bad++;
      $display("FAIL glitch_valid got dv=%b n=%0d want 0", dv_a, obs_a.size());
    end
    @(negedge clk);
  endtask

  task automatic test_overrun();
    rdy_a = 1'b0;
    send_a(fr_a(8'h11, 1'b1), 10);
    send_a('1, 1);
    send_a(fr_a(8'h22, 1'b1), 10);
    send_a('1, 2);
    #1;
    n_cmp++;
    if (dv_a !== 1'b1) begin
      n_bad++;
      $display("FAIL ovr_valid got %b want 1", dv_a);
    end
    n_cmp++;
    if (data_a !== 8'h11) begin
      n_bad++;
      $display("FAIL ovr_data got %h want 11", data_a);
    end
    n_cmp++;
    if (ov_a !== 1'b1) begin
      n_bad++;
      $display("FAIL ovr_flag got %b want 1", ov_a);
    end
    exp_a.push_back(mk(9'h011, 0, 0, 0));
    @(negedge clk);
    rdy_a = 1'b1;
    wait_obs_a(1);
    @(negedge clk);
    #1;
    n_cmp++;
    if ({dv_a, ov_a} !== 2'b00) begin
      n_bad++;
      $display("FAIL ovr_clear got dv=%b ov=%b want 0 0", dv_a, ov_a);
    end
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front();
      n_cmp++;
      if (obs_a.size() == 0) begin
        n_bad++;
        $display("FAIL ovr_word got none want %h", e);
      end else begin
        o = obs_a.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL ovr_word got %h want %h", o, e);
        end
      end
    end
    obs_a.delete();
    @(negedge clk);
  endtask

  task automatic test_abort();
    rdy_a = 1'b1;
    send_a(fr_a(8'hF0, 1'b1), 4);
    rx_en = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_busy got %b want 0", busy_a);
    end
    @(negedge clk);
    rx_a = 1'b1;
    rx_en = 1'b1;
    send_a('1, 8);
    #1;
    n_cmp++;
    if ({dv_a, 8'(obs_a.size())} !== 9'h0) begin
      n_bad++;
      $display("FAIL abort_out got dv=%b n=%0d want 0", dv_a, obs_a.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    rdy_a = 1'b0;
    send_a(fr_a(8'h77, 1'b1), 10);
    send_a('1, 1);
    #1;
    n_cmp++;
    if ({dv_a, data_a} !== 9'h177) begin
      n_bad++;
      $display("FAIL rst_held got %h want 177", {dv_a, data_a});
    end
    send_a(fr_a(8'hA5, 1'b1), 5);
    #1;
    n_cmp++;
    if (busy_a !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_busy got %b want 1", busy_a);
    end
    #2 arst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy_a, dv_a, pe_a, fe_a, bk_a, ov_a, data_a} !== 14'h0) begin
      n_bad++;
      $display("FAIL rst_async got %h want 0",
               {busy_a, dv_a, pe_a, fe_a, bk_a, ov_a, data_a});
    end
    @(negedge clk);
    rx_a = 1'b1;
    arst_n = 1'b1;
    send_a('1, 2);
    rdy_a = 1'b1;
    exp_a.push_back(mk(9'h03C, 0, 0, 0));
    send_a(fr_a(8'h3C, 1'b1), 10);
    send_a('1, 2);
    wait_obs_a(1);
    n_cmp++;
    if (obs_a.size() !== exp_a.size()) begin
      n_bad++;
      $display("FAIL rst_count got %0d want %0d", obs_a.size(), exp_a.size());
    end
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front();
      n_cmp++;
      if (obs_a.size() == 0) begin
        n_bad++;
        $display("FAIL rst_word got none want %h", e);
      end else begin
        o = obs_a.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL rst_word got %h want %h", o, e);
        end
      end
    end
    obs_a.delete();
  endtask

  initial begin
    busy_seen_a = 1'b0;
    test_reset();
    test_back_to_back();
    test_parity();
    test_frame_break();
    test_glitch();
    test_overrun();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
